// File: rtl/pipe_pkg.sv
// Shared fetch/decode pipeline types: the canonical NOP, the skid-buffer
// state encoding and the instruction/PC pair carried between stages.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR_RV32 = 32'h0000_0013;  // addi x0,x0,0

    localparam int unsigned IF_ID_ILEN = 32;
    localparam int unsigned IF_ID_XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [IF_ID_ILEN-1:0] instr;
        logic [IF_ID_XLEN-1:0] pc;
    } if_id_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug: counts enabled cycles and
// sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Synchronous active-low clear; increment only while below all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/ir_skid_reg.sv
// Fetch-to-decode instruction/PC register with a two-entry skid buffer.
//
//   state | meaning
//   EMPTY | nothing held, main entry presents the NOP
//   ONE   | main entry holds a valid word
//   FULL  | main and skid entries both hold valid words (main is older)
//
// in_ready is decoded from the registered state only, so there is no
// combinational path from out_ready back to fetch.
module ir_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned         XLEN      = 32,
    parameter int unsigned         ILEN      = 32,
    parameter logic [ILEN-1:0]     NOP_INSTR = ILEN'(NOP_INSTR_RV32),
    parameter int unsigned         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ILEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ILEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    skid_state_e     r_state;
    skid_state_e     w_state_nxt;

    logic [ILEN-1:0] r_main_instr;
    logic [XLEN-1:0] r_main_pc;
    logic [ILEN-1:0] r_skid_instr;
    logic [XLEN-1:0] r_skid_pc;

    logic [ILEN-1:0] w_main_instr_nxt;
    logic [XLEN-1:0] w_main_pc_nxt;
    logic [ILEN-1:0] w_skid_instr_nxt;
    logic [XLEN-1:0] w_skid_pc_nxt;

    logic            w_in_fire;
    logic            w_out_fire;

    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state != EMPTY);
    assign out_instr  = r_main_instr;
    assign out_pc     = r_main_pc;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // State and entry registers; reset presents the NOP at PC 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= EMPTY;
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_main_instr <= w_main_instr_nxt;
            r_main_pc    <= w_main_pc_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
        end
    end

    // Next state and entry contents; flush overrides every handshake.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_instr_nxt = r_main_instr;
        w_main_pc_nxt    = r_main_pc;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;

        if (flush) begin
            // Incoming word is discarded and the skid entry is simply
            // abandoned; the PC is left as-is, only the instruction is killed.
            w_state_nxt      = EMPTY;
            w_main_instr_nxt = NOP_INSTR;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt      = ONE;
                        w_main_instr_nxt = in_instr;
                        w_main_pc_nxt    = in_pc;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_instr_nxt = in_instr;
                        w_main_pc_nxt    = in_pc;
                    end else if (w_in_fire) begin
                        w_state_nxt      = FULL;
                        w_skid_instr_nxt = in_instr;
                        w_skid_pc_nxt    = in_pc;
                    end else if (w_out_fire) begin
                        w_state_nxt      = EMPTY;
                        w_main_instr_nxt = NOP_INSTR;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (w_out_fire) begin
                        w_state_nxt      = ONE;
                        w_main_instr_nxt = r_skid_instr;
                        w_main_pc_nxt    = r_skid_pc;
                    end
                end
                default: begin
                    w_state_nxt      = EMPTY;
                    w_main_instr_nxt = NOP_INSTR;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush),
        .count (flush_cnt)
    );

endmodule
